// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU front end: stream target codes,
// loader FSM states and default datapath widths.
package tpu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned ADDR_W_DEFAULT = 8;

  localparam logic [1:0] TGT_WEIGHT = 2'b00;
  localparam logic [1:0] TGT_INPUT  = 2'b01;
  localparam logic [1:0] TGT_START  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    PAYLOAD  = 3'd3,
    RUN      = 3'd4
  } state_e;

endpackage : tpu_pkg

// File: rtl/host_stream_loader.sv
// Decodes a host word stream into weight/input memory writes and TPU start
// commands; holds off the host while the TPU runs.
module host_stream_loader
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wmem_we,
  output logic              umem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              start,
  input  logic              tpu_done,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                wmem_we_q, wmem_we_d;
  logic                umem_we_q, umem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;
  logic                err_q, err_d;
  logic                xfer;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wmem_we_d   = 1'b0;
    umem_we_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    start_d     = 1'b0;
    load_done_d = 1'b0;
    err_d       = err_q;
    xfer        = in_valid && in_ready_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          case (in_data[1:0])
            TGT_WEIGHT, TGT_INPUT: begin
              tgt_d   = in_data[1:0];
              state_d = GET_ADDR;
            end
            TGT_START: begin
              start_d = 1'b1;
              state_d = RUN;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      GET_ADDR: begin
        if (xfer) begin
          addr_d  = ADDR_W'(in_data);
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (xfer) begin
          cnt_d = ADDR_W'(in_data);
          if (ADDR_W'(in_data) == ADDR_W'(0)) begin
            load_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          wmem_we_d   = (tgt_q == TGT_WEIGHT);
          umem_we_d   = (tgt_q == TGT_INPUT);
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = ADDR_W'(addr_q + ADDR_W'(1));
          cnt_d       = ADDR_W'(cnt_q - ADDR_W'(1));
          if (cnt_q == ADDR_W'(1)) begin
            load_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      RUN: begin
        // A done that lines up with the start pulse belongs to a previous run
        if (tpu_done && !start_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != RUN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      tgt_q       <= 2'b00;
      addr_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      wmem_we_q   <= 1'b0;
      umem_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      wmem_we_q   <= wmem_we_d;
      umem_we_q   <= umem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wmem_we   = wmem_we_q;
  assign umem_we   = umem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule : host_stream_loader

// File: tb/tb_host_stream_loader.sv
// Bench for host_stream_loader: directed and randomized packets compared
// against an event list derived from the packet format.
module tb_host_stream_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wmem_we;
  logic          umem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          start;
  logic          tpu_done;
  logic          busy;
  logic          load_done;
  logic          err;

  host_stream_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wmem_we(wmem_we), .umem_we(umem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start),
    .tpu_done(tpu_done), .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     w;
    logic     u;
    logic [7:0] a;
    logic [7:0] d;
    logic     ld;
    int       cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  int         cyc = 0;
  int         both_cnt = 0;
  int         start_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pl_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every write or load_done pulse becomes an event
  always @(negedge clk) begin
    if (wmem_we && umem_we) both_cnt++;
    if (start) start_cnt++;
    if (wmem_we || umem_we || load_done) begin
      mon_e.w = wmem_we; mon_e.u = umem_we; mon_e.a = mem_addr;
      mon_e.d = mem_wdata; mon_e.ld = load_done; mon_e.cyc = cyc;
      obs_q.push_back(mon_e);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".wmem_we"}, wmem_we, 0);
    check({tag, ".umem_we"}, umem_we, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
    check({tag, ".start"}, start, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".load_done"}, load_done, 0);
    check({tag, ".err"}, err, 0);
  endtask

  // Present one word after `gap` idle cycles; returns once the handshake edge is committed
  task automatic send_word(input logic [7:0] w, input int gap);
    int  tries = 0;
    bit  done  = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    while (!done && tries < 500) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      if (in_ready) done = 1;
      tries++;
    end
    check("handshake_timeout", 32'(done), 1);
  endtask

  // Reference: a load of n words yields writes at (base+k) mod 256, done on the last
  task automatic model_load(input logic [1:0] tgt, input logic [7:0] base, input logic [7:0] pl[$]);
    ev_t e;
    int  n = pl.size();
    for (int k = 0; k < n; k++) begin
      e.w = (tgt == 2'd0); e.u = (tgt == 2'd1);
      e.a = 8'((int'(base) + k) % 256); e.d = pl[k];
      e.ld = (k == n - 1); e.cyc = 0;
      exp_q.push_back(e);
    end
    if (n == 0) begin
      e.w = 0; e.u = 0; e.a = 0; e.d = 0; e.ld = 1; e.cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_load(input logic [7:0] hdr, input logic [7:0] base,
                           input logic [7:0] pl[$], input int gap_max, input bit alt);
    int g;
    model_load(hdr[1:0], base, pl);
    send_word(hdr, 0);
    send_word(base, alt ? 1 : $urandom_range(0, gap_max));
    send_word(8'(pl.size()), alt ? 1 : $urandom_range(0, gap_max));
    foreach (pl[k]) begin
      g = alt ? 1 : $urandom_range(0, gap_max);
      send_word(pl[k], g);
    end
  endtask

  task automatic compare(input string tag, input bit b2b);
    int n;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.w%0d", tag, i), obs_q[i].w, exp_q[i].w);
      check($sformatf("%s.u%0d", tag, i), obs_q[i].u, exp_q[i].u);
      check($sformatf("%s.ld%0d", tag, i), obs_q[i].ld, exp_q[i].ld);
      if (exp_q[i].w || exp_q[i].u) begin
        check($sformatf("%s.a%0d", tag, i), obs_q[i].a, exp_q[i].a);
        check($sformatf("%s.d%0d", tag, i), obs_q[i].d, exp_q[i].d);
      end
      if (b2b && i > 0)
        check($sformatf("%s.gap%0d", tag, i), 32'(obs_q[i].cyc - obs_q[i-1].cyc), 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         run_bad;
    logic [7:0] hdr;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tpu_done = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("post_reset.in_ready", in_ready, 1);
    check("post_reset.busy", busy, 0);

    pl_q = '{8'hA1, 8'hA2, 8'hA3};
    send_load(8'h00, 8'h10, pl_q, 0, 0);
    compare("weight_b2b", 1);

    pl_q = '{8'h05, 8'h06, 8'h07};
    send_load(8'h01, 8'hFE, pl_q, 0, 1);
    compare("wrap_stall", 0);

    // Start command; a done coincident with start must be ignored
    send_word(8'hA6, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h03;
    tpu_done = 1'b1;
    check("start.pulse", start, 1);
    check("start.in_ready", in_ready, 0);
    check("start.busy", busy, 1);
    @(negedge clk);
    tpu_done = 1'b0;
    check("start.single", start, 0);
    check("start.coincident_done_ignored", busy, 1);
    run_bad = 0;
    repeat (18) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b1) run_bad++;
    end
    check("run.held", run_bad, 0);
    in_valid = 1'b0;
    tpu_done = 1'b1;
    @(negedge clk);
    tpu_done = 1'b0;
    check("run_exit.in_ready", in_ready, 1);
    check("run_exit.busy", busy, 0);
    check("run_exit.no_consume", err, 0);
    check("run.no_writes", obs_q.size(), 0);

    pl_q.delete();
    send_load(8'h00, 8'h40, pl_q, 0, 0);
    compare("zero_len", 0);
    send_word(8'h03, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bad_hdr.err", err, 1);
    check("bad_hdr.busy", busy, 0);
    pl_q = '{8'h11, 8'h22};
    send_load(8'h01, 8'h80, pl_q, 1, 0);
    compare("after_err", 0);
    check("err.sticky", err, 1);

    // Reset after two of four payload words
    exp_q.delete();
    pl_q = '{8'hC1, 8'hC2};
    model_load(2'd0, 8'h20, pl_q);
    exp_q[1].ld = 1'b0;
    send_word(8'h00, 0);
    send_word(8'h20, 0);
    send_word(8'h04, 0);
    send_word(8'hC1, 0);
    send_word(8'hC2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset.release_ready", in_ready, 1);
    pl_q = '{8'h55};
    send_load(8'h00, 8'h00, pl_q, 0, 0);
    compare("after_reset", 0);

    // Randomized loads; tpu_done held high outside RUN must be ignored
    tpu_done = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = (r == 0) ? 0 : (r == 7) ? 255 : $urandom_range(1, 20);
      pl_q.delete();
      for (int k = 0; k < n; k++) pl_q.push_back(8'($urandom));
      hdr = 8'(($urandom & 32'hFC) | 32'($urandom_range(0, 1)));
      send_load(hdr, 8'($urandom), pl_q, 2, 0);
      compare($sformatf("rand%0d", r), 0);
    end
    tpu_done = 1'b0;

    check("never_both_we", both_cnt, 0);
    check("start_count", start_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_host_stream_loader
